sip_bitserial_mac: RTL and testbench

//  Bit-serial successor to the single-shot SIP dot/adder pair. Takes one bit-plane pair (N_DOT lanes x BITS_PAR bits) per beat,

---
 rtl/sip_bitserial_mac.sv | 174 +++++++++++++++++
 tb/tb_sip_bitserial_mac.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sip_bitserial_mac.sv
// Bit-serial signed dot product: one bit-plane pair per beat, 3-stage product/tree/shift-accumulate pipe.
// Result 3 cycles after the last beat, held until i_ResReady; o_Ready is high only while the job's beats are due.
module sip_bitserial_mac #(
    parameter int  N_DOT      = 32,
    parameter int  BITS_PAR   = 1,
    parameter int  MAX_PLANES = 8,
    parameter int  BITS_ACC   = 32,
    localparam int PW         = $clog2(MAX_PLANES + 1)
) (
    input  logic                      i_CLK,
    input  logic                      i_RSTn,
    input  logic                      i_Start,
    input  logic [PW-1:0]             i_PrecA,
    input  logic [PW-1:0]             i_PrecW,
    input  logic                      i_SignA,
    input  logic                      i_SignW,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic [N_DOT*BITS_PAR-1:0] i_Act,
    input  logic [N_DOT*BITS_PAR-1:0] i_Weight,
    output logic                      o_Valid,
    input  logic                      i_ResReady,
    output logic [BITS_ACC-1:0]       o_Result,
    output logic                      o_Busy
);

    localparam int PRODW = 2*BITS_PAR + 2;
    localparam int SUMW  = PRODW + $clog2(N_DOT);
    localparam int SW    = $clog2(2*MAX_PLANES*BITS_PAR);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q;
    logic [PW-1:0] prec_a_q, prec_w_q, ia_q, iw_q;
    logic          sign_a_q, sign_w_q;
    logic          ready_q, valid_q, busy_q;
    logic [1:0]    drain_q;

    logic                             s1_vld_q, s2_vld_q;
    logic [N_DOT-1:0][PRODW-1:0]      s1_prod_q;
    logic [SW-1:0]                    s1_sh_q, s2_sh_q;
    logic signed [SUMW-1:0]           s2_sum_q;
    logic [BITS_ACC-1:0]              acc_q;

    logic [N_DOT-1:0][PRODW-1:0]      prod_d;
    logic [SW-1:0]                    sh_d;
    logic signed [SUMW-1:0]           sum_d;
    logic signed [BITS_ACC-1:0]       addend_d;
    logic                             accept, start_ok, last_beat, msb_a, msb_w;

    function automatic logic [PW-1:0] eff_prec(input logic [PW-1:0] p);
        if (p == '0)
            return PW'(1);
        if (p > PW'(MAX_PLANES))
            return PW'(MAX_PLANES);
        return p;
    endfunction

    assign accept    = i_Valid & ready_q;
    assign start_ok  = (state_q == S_IDLE) & i_Start;
    assign last_beat = (ia_q == prec_a_q - PW'(1)) && (iw_q == prec_w_q - PW'(1));
    assign msb_a     = sign_a_q && (ia_q == prec_a_q - PW'(1));
    assign msb_w     = sign_w_q && (iw_q == prec_w_q - PW'(1));
    assign sh_d      = SW'((32'(ia_q) + 32'(iw_q)) * BITS_PAR);

    // Only the top plane of a signed operand carries negative weight.
    for (genvar k = 0; k < N_DOT; k++) begin : g_lane
        logic [BITS_PAR-1:0]     a_sl, w_sl;
        logic signed [BITS_PAR:0] a_ext, w_ext;
        logic signed [PRODW-1:0]  prod;
        assign a_sl  = i_Act[k*BITS_PAR +: BITS_PAR];
        assign w_sl  = i_Weight[k*BITS_PAR +: BITS_PAR];
        assign a_ext = msb_a ? {a_sl[BITS_PAR-1], a_sl} : {1'b0, a_sl};
        assign w_ext = msb_w ? {w_sl[BITS_PAR-1], w_sl} : {1'b0, w_sl};
        assign prod  = a_ext * w_ext;
        assign prod_d[k] = prod;
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_DOT; k++)
            sum_d = sum_d + SUMW'($signed(s1_prod_q[k]));
    end

    assign addend_d = BITS_ACC'(s2_sum_q);

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q  <= S_IDLE;
            prec_a_q <= PW'(1);
            prec_w_q <= PW'(1);
            sign_a_q <= 1'b0;
            sign_w_q <= 1'b0;
            ia_q     <= '0;
            iw_q     <= '0;
            drain_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (i_Start) begin
                    prec_a_q <= eff_prec(i_PrecA);
                    prec_w_q <= eff_prec(i_PrecW);
                    sign_a_q <= i_SignA;
                    sign_w_q <= i_SignW;
                    ia_q     <= '0;
                    iw_q     <= '0;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b1;
                    state_q  <= S_RUN;
                end
                S_RUN: if (accept) begin
                    if (last_beat) begin
                        ready_q <= 1'b0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else if (ia_q == prec_a_q - PW'(1)) begin
                        ia_q <= '0;
                        iw_q <= iw_q + PW'(1);
                    end else begin
                        ia_q <= ia_q + PW'(1);
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    if (drain_q == 2'd2) begin
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: if (i_ResReady) begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            s1_vld_q  <= 1'b0;
            s1_prod_q <= '0;
            s1_sh_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_sum_q  <= '0;
            s2_sh_q   <= '0;
            acc_q     <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_prod_q <= prod_d;
                s1_sh_q   <= sh_d;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_sum_q <= sum_d;
                s2_sh_q  <= s1_sh_q;
            end
            if (start_ok)
                acc_q <= '0;
            else if (s2_vld_q)
                acc_q <= acc_q + (addend_d <<< s2_sh_q);
        end
    end

    assign o_Ready  = ready_q;
    assign o_Valid  = valid_q;
    assign o_Busy   = busy_q;
    assign o_Result = acc_q;

endmodule

// File: tb/tb_sip_bitserial_mac.sv
// Directed bench for sip_bitserial_mac with a golden sum(a*w) scoreboard per job.
module tb_sip_bitserial_mac;
    localparam int N = 32;

    logic          i_CLK = 1'b0;
    logic          i_RSTn, i_Start, i_SignA, i_SignW, i_Valid, i_ResReady;
    logic [3:0]    i_PrecA, i_PrecW;
    logic [N-1:0]  i_Act, i_Weight;
    logic          o_Ready, o_Valid, o_Busy;
    logic [31:0]   o_Result;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   last_exp;
    int            a_val[N];
    int            w_val[N];

    sip_bitserial_mac dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_Start(i_Start),
        .i_PrecA(i_PrecA), .i_PrecW(i_PrecW), .i_SignA(i_SignA), .i_SignW(i_SignW),
        .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Act(i_Act), .i_Weight(i_Weight),
        .o_Valid(o_Valid), .i_ResReady(i_ResReady), .o_Result(o_Result), .o_Busy(o_Busy)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int eff(input int p);
        if (p == 0) return 1;
        if (p > 8) return 8;
        return p;
    endfunction

    function automatic logic [N-1:0] plane(input bit is_act, input int p);
        logic [N-1:0] r;
        int v;
        for (int k = 0; k < N; k++) begin
            v = is_act ? a_val[k] : w_val[k];
            r[k] = v[p];
        end
        return r;
    endfunction

    task automatic start_job(input int pa, input int pw, input bit sa, input bit sw);
        longint s = 0;
        for (int k = 0; k < N; k++)
            s += longint'(a_val[k]) * longint'(w_val[k]);
        exp_q.push_back(s[31:0]);
        i_PrecA = 4'(pa);
        i_PrecW = 4'(pw);
        i_SignA = sa;
        i_SignW = sw;
        i_Start = 1'b1;
        @(posedge i_CLK); #1;
        i_Start = 1'b0;
    endtask

    // Drives all plane pairs (or stops early after stop_after beats), then checks latency and result.
    task automatic send_job(input int pa, input int pw, input bit gaps, input int stop_after);
        int  ea = eff(pa);
        int  ew = eff(pw);
        int  n;
        int  beats = 0;
        bit  rdy;
        for (int iw = 0; iw < ew; iw++) begin
            for (int ia = 0; ia < ea; ia++) begin
                if (beats == stop_after) begin
                    i_Valid = 1'b0;
                    return;
                end
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        i_Valid = 1'b0;
                        @(posedge i_CLK); #1;
                    end
                end
                i_Valid  = 1'b1;
                i_Act    = plane(1'b1, ia);
                i_Weight = plane(1'b0, iw);
                rdy = 1'b0;
                n = 0;
                while (!rdy && n < 50) begin
                    rdy = o_Ready;
                    @(posedge i_CLK); #1;
                    n++;
                end
                chk("beat_accept", 32'(rdy), 32'd1);
                if (!rdy) begin
                    i_Valid = 1'b0;
                    return;
                end
                beats++;
            end
        end
        i_Valid = 1'b0;
        chk("ready_drop", 32'(o_Ready), 32'd0);
        chk("busy_run", 32'(o_Busy), 32'd1);
        n = 0;
        while (!o_Valid && n < 20) begin
            @(posedge i_CLK); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        last_exp = exp_q.pop_front();
        chk("result", o_Result, last_exp);
    endtask

    task automatic consume();
        i_ResReady = 1'b1;
        @(posedge i_CLK); #1;
        i_ResReady = 1'b0;
        chk("valid_clear", 32'(o_Valid), 32'd0);
        chk("busy_clear", 32'(o_Busy), 32'd0);
    endtask

    initial begin
        i_RSTn = 1'b0; i_Start = 1'b0; i_SignA = 1'b0; i_SignW = 1'b0;
        i_Valid = 1'b0; i_ResReady = 1'b0; i_PrecA = '0; i_PrecW = '0;
        i_Act = '0; i_Weight = '0;
        repeat (3) @(posedge i_CLK);
        #1;
        chk("rst_ready", 32'(o_Ready), 32'd0);
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_result", o_Result, 32'd0);
        i_RSTn = 1'b1;
        @(posedge i_CLK); #1;

        // Single-plane unsigned job, all ones: 32.
        for (int k = 0; k < N; k++) begin a_val[k] = 1; w_val[k] = 1; end
        start_job(1, 1, 1'b0, 1'b0);
        send_job(1, 1, 1'b0, -1);
        chk("t1_abs", o_Result, 32'd32);
        consume();

        // 4b x 4b unsigned, 5*3 per lane: 480.
        for (int k = 0; k < N; k++) begin a_val[k] = 5; w_val[k] = 3; end
        start_job(4, 4, 1'b0, 1'b0);
        send_job(4, 4, 1'b0, -1);
        chk("t2_abs", o_Result, 32'd480);
        consume();

        // Signed x signed: (-3)(-2)*32 = 192, then (-8)(7)*32 = -1792.
        for (int k = 0; k < N; k++) begin a_val[k] = -3; w_val[k] = -2; end
        start_job(4, 4, 1'b1, 1'b1);
        send_job(4, 4, 1'b0, -1);
        chk("t3a_abs", o_Result, 32'd192);
        consume();
        for (int k = 0; k < N; k++) begin a_val[k] = -8; w_val[k] = 7; end
        start_job(4, 4, 1'b1, 1'b1);
        send_job(4, 4, 1'b0, -1);
        chk("t3b_abs", o_Result, 32'hFFFF_F900);
        consume();

        // Precision clamping: PrecA=0 acts as 1, PrecW=15 acts as 8.
        for (int k = 0; k < N; k++) begin
            a_val[k] = int'($urandom_range(0, 1));
            w_val[k] = int'($urandom_range(0, 255));
        end
        start_job(0, 15, 1'b0, 1'b0);
        send_job(0, 15, 1'b1, -1);
        consume();

        // 8b signed A x 2b unsigned W with random gaps; result left pending for the hold test.
        for (int k = 0; k < N; k++) begin
            a_val[k] = int'($urandom_range(0, 255)) - 128;
            w_val[k] = int'($urandom_range(0, 3));
        end
        start_job(8, 2, 1'b1, 1'b0);
        send_job(8, 2, 1'b1, -1);

        // Result held under backpressure; start pulses and beats are ignored.
        for (int c = 0; c < 10; c++) begin
            i_Start = (c == 3);
            i_Valid = 1'b1;
            i_PrecA = 4'd1;
            i_PrecW = 4'd1;
            @(posedge i_CLK); #1;
            chk("hold_valid", 32'(o_Valid), 32'd1);
            chk("hold_result", o_Result, last_exp);
            chk("hold_ready", 32'(o_Ready), 32'd0);
        end
        i_Start = 1'b0;
        i_Valid = 1'b0;
        consume();
        chk("no_ghost_job", 32'(o_Ready), 32'd0);

        // Reset mid-job after 5 of 16 beats discards the job.
        for (int k = 0; k < N; k++) begin
            a_val[k] = int'($urandom_range(0, 15));
            w_val[k] = int'($urandom_range(0, 15));
        end
        start_job(4, 4, 1'b0, 1'b0);
        send_job(4, 4, 1'b0, 5);
        void'(exp_q.pop_back());
        #2 i_RSTn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(o_Ready), 32'd0);
        chk("mid_rst_valid", 32'(o_Valid), 32'd0);
        chk("mid_rst_busy", 32'(o_Busy), 32'd0);
        chk("mid_rst_result", o_Result, 32'd0);
        @(posedge i_CLK); #1;
        i_RSTn = 1'b1;
        repeat (6) @(posedge i_CLK);
        #1;
        chk("post_rst_valid", 32'(o_Valid), 32'd0);

        for (int k = 0; k < N; k++) begin
            a_val[k] = int'($urandom_range(0, 15)) - 8;
            w_val[k] = int'($urandom_range(0, 15));
        end
        start_job(4, 4, 1'b1, 1'b0);
        send_job(4, 4, 1'b1, -1);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
